mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Control FSM for the add-shift signed multiplier datapath (A/B regs, X flip-flop, 9-bit adder).
//  Sequences WIDTH add/shift iterations from multiplier LSB M and issues all clear/load/add/shift strobes.
//  Reports progress and completion.
//  Sits between the synchronized buttons (Run, ClearA_LoadB) and the datapath registers.
// PARAMETERS
//  WIDTH         8  operand width = number of iterations; CNT_W = $clog2(WIDTH+1) (localparam)
//  CLEAR_ON_RUN  1  1: clear A and X before each run; 0: accumulate onto existing A/X
// PORTS
//  Clk           in   1      system clock, all logic on rising edge
//  Reset         in   1      synchronous, active-high
//  Run           in   1      level, already synchronized; start request
//  ClearA_LoadB  in   1      level, already synchronized; clear A/X and load B from switches
//  M             in   1      current B[0] (multiplier bit)
//  ClearAX       out  1      clear A register and X flip-flop
//  LoadB         out  1      parallel-load B from switch data
//  AddEn         out  1      load adder result into A and X
//  Sub_Add       out  1      1: adder subtracts (A - S); 0: adds (A + S)
//  Shift         out  1      arithmetic right shift of X->A->B
//  Busy          out  1      high in CLR/ADD/SHIFT
//  Done          out  1      high in DONE
//  Iter          out  CNT_W  shifts completed this run, 0..WIDTH
// BEHAVIOUR
//  States: IDLE, CLR, ADD, SHIFT, DONE. Reset -> IDLE, Iter=0; all outputs 0 while Reset high.
//  IDLE:
//   - Run=1 -> CLR (CLEAR_ON_RUN=1) or ADD (CLEAR_ON_RUN=0); Iter<=0.
//   - Run=0 with ClearA_LoadB=1: ClearAX=LoadB=1 combinationally this cycle, stay IDLE.
//   - Run and ClearA_LoadB both high: Run wins, no ClearAX/LoadB.
//  CLR: ClearAX=1 for one cycle -> ADD.
//  ADD:
//   - AddEn=M.
//   - Sub_Add=1 iff Iter==WIDTH-1 (sign-bit step subtracts), else 0.
//   - -> SHIFT.
//  SHIFT:
//   - Shift=1; Iter<=Iter+1.
//   - Iter==WIDTH-1 -> DONE, else -> ADD.
//  DONE: Iter holds WIDTH; stay while Run=1, Run=0 -> IDLE. One product per Run press.
//  Latency from Run sampled high in IDLE:
//   - Busy lasts 1+2*WIDTH cycles (17) with CLEAR_ON_RUN=1, else 2*WIDTH (16).
//   - Done rises the cycle after.
//  Strobes: only in the listed state; Sub_Add=0 outside ADD. At most one of ClearAX/AddEn/Shift high,
//   except the ClearAX+LoadB pair in IDLE.
//  ClearA_LoadB ignored outside IDLE. Reset mid-run: next cycle IDLE, Iter=0, Busy=0, no residual strobe.
//  Iter never exceeds WIDTH; no wrap.
// TESTING
//  1 Reset, then ClearA_LoadB=1 for 1 cycle in IDLE -> ClearAX=LoadB=1 that cycle only; AddEn=Shift=0.
//  2 Run held high, M=1 every ADD (B=8'hFF) -> 1 ClearAX, 8 AddEn pulses (Sub_Add only with 8th),
//    8 Shift pulses interleaved, Busy 17 cycles, Done=1, Iter=8.
//  3 M=0 every ADD -> AddEn never high, 8 Shift pulses, Done after 17 cycles.
//  4 Run kept high after Done -> stays DONE, no new strobes; Run=0 -> IDLE next cycle; Run=1 -> new run.
//  5 Reset during ADD with Iter=4 -> all strobes 0 while Reset high; next cycle IDLE, Iter=0, Busy=0.
//  6 CLEAR_ON_RUN=0 build; Run with ClearA_LoadB=1 -> no ClearAX/LoadB, Busy 16 cycles;
//    ClearA_LoadB pulsed mid-run is ignored.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control FSM for the add-shift signed multiplier: sequences WIDTH add/shift
// iterations from multiplier bit M and drives every datapath strobe.
module mult_sequencer #(
    parameter int WIDTH        = 8,
    parameter bit CLEAR_ON_RUN = 1'b1,
    localparam int CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             M,
    output logic             ClearAX,
    output logic             LoadB,
    output logic             AddEn,
    output logic             Sub_Add,
    output logic             Shift,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    logic clear_ax_r, load_b_r, add_en_r, sub_add_r, shift_r, busy_r, done_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Run is a level request: a run starts when Run is seen high in IDLE, and
    // the FSM parks in DONE until Run drops, giving one product per press.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        clear_ax_r = 1'b0;
        load_b_r   = 1'b0;
        add_en_r   = 1'b0;
        sub_add_r  = 1'b0;
        shift_r    = 1'b0;
        busy_r     = 1'b0;
        done_r     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = CLEAR_ON_RUN ? S_CLR : S_ADD;
                    iter_d  = '0;
                end else if (ClearA_LoadB) begin
                    clear_ax_r = 1'b1;
                    load_b_r   = 1'b1;
                end
            end
            S_CLR: begin
                clear_ax_r = 1'b1;
                busy_r     = 1'b1;
                state_d    = S_ADD;
            end
            S_ADD: begin
                busy_r    = 1'b1;
                add_en_r  = M;
                // The final iteration weighs the sign bit, so it subtracts.
                sub_add_r = (iter_q == LAST_ITER);
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                busy_r  = 1'b1;
                shift_r = 1'b1;
                iter_d  = iter_q + CNT_W'(1);
                state_d = (iter_q == LAST_ITER) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done_r = 1'b1;
                if (!Run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset is synchronous, so the stale state is still visible during the
    // reset cycle; mask everything so no strobe leaks while Reset is high.
    assign ClearAX   = clear_ax_r & ~Reset;
    assign LoadB     = load_b_r   & ~Reset;
    assign AddEn     = add_en_r   & ~Reset;
    assign Sub_Add   = sub_add_r  & ~Reset;
    assign Shift     = shift_r    & ~Reset;
    assign Busy      = busy_r     & ~Reset;
    assign Done      = done_r     & ~Reset;
    assign Iter      = Reset ? '0 : iter_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: one instance with CLEAR_ON_RUN=1 and one
// with CLEAR_ON_RUN=0 share clock and reset.
module tb_mult_sequencer;

    logic       Clk;
    logic       Reset;
    logic       run_a, clab_a, m_a;
    logic       run_b, clab_b, m_b;

    logic       clear_ax_a, load_b_a, add_en_a, sub_add_a, shift_a, busy_a, done_a;
    logic [3:0] iter_a;
    logic [2:0] state_a;
    logic       clear_ax_b, load_b_b, add_en_b, sub_add_b, shift_b, busy_b, done_b;
    logic [3:0] iter_b;
    logic [2:0] state_b;

    int checks = 0;
    int errors = 0;

    mult_sequencer #(.WIDTH(8), .CLEAR_ON_RUN(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Run(run_a), .ClearA_LoadB(clab_a), .M(m_a),
        .ClearAX(clear_ax_a), .LoadB(load_b_a), .AddEn(add_en_a), .Sub_Add(sub_add_a),
        .Shift(shift_a), .Busy(busy_a), .Done(done_a), .Iter(iter_a), .dbg_state(state_a)
    );

    mult_sequencer #(.WIDTH(8), .CLEAR_ON_RUN(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Run(run_b), .ClearA_LoadB(clab_b), .M(m_b),
        .ClearAX(clear_ax_b), .LoadB(load_b_b), .AddEn(add_en_b), .Sub_Add(sub_add_b),
        .Shift(shift_b), .Busy(busy_b), .Done(done_b), .Iter(iter_b), .dbg_state(state_b)
    );

    // clock block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Output vector order: {ClearAX, LoadB, AddEn, Sub_Add, Shift, Busy, Done}
    task automatic chk_a(input string tag, input logic [6:0] exp_o, input logic [3:0] exp_i);
        logic [6:0] obs;
        obs = {clear_ax_a, load_b_a, add_en_a, sub_add_a, shift_a, busy_a, done_a};
        checks++;
        assert (obs === exp_o && iter_a === exp_i) else begin
            errors++;
            $error("FAIL %s: observed strobes=%b iter=%0d, expected strobes=%b iter=%0d",
                   tag, obs, iter_a, exp_o, exp_i);
        end
    endtask

    task automatic chk_b(input string tag, input logic [6:0] exp_o, input logic [3:0] exp_i);
        logic [6:0] obs;
        obs = {clear_ax_b, load_b_b, add_en_b, sub_add_b, shift_b, busy_b, done_b};
        checks++;
        assert (obs === exp_o && iter_b === exp_i) else begin
            errors++;
            $error("FAIL %s: observed strobes=%b iter=%0d, expected strobes=%b iter=%0d",
                   tag, obs, iter_b, exp_o, exp_i);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] obs, input logic [2:0] exp_s);
        checks++;
        assert (obs === exp_s) else begin
            errors++;
            $error("FAIL %s: observed state=%0d, expected state=%0d", tag, obs, exp_s);
        end
    endtask

    initial begin
        Reset = 1'b1;
        run_a = 1'b0; clab_a = 1'b0; m_a = 1'b0;
        run_b = 1'b0; clab_b = 1'b0; m_b = 1'b0;

        // reset: outputs masked even with a clear request present
        tick();
        clab_a = 1'b1;
        #1;
        chk_a("reset_masks_clab", 7'b0000000, 4'd0);
        tick();
        chk_state("reset_state_a", state_a, 3'd0);
        clab_a = 1'b0;
        Reset  = 1'b0;
        tick();
        chk_a("idle_after_reset", 7'b0000000, 4'd0);
        chk_b("idle_after_reset_b", 7'b0000000, 4'd0);

        // ClearA_LoadB in IDLE: pair asserted that cycle only
        clab_a = 1'b1;
        #1;
        chk_a("idle_clear_load", 7'b1100000, 4'd0);
        tick();
        clab_a = 1'b0;
        #1;
        chk_a("idle_clear_load_drop", 7'b0000000, 4'd0);

        // full run with M=1; Run and ClearA_LoadB together: Run wins
        m_a = 1'b1; run_a = 1'b1; clab_a = 1'b1;
        #1;
        chk_a("run_wins_over_clab", 7'b0000000, 4'd0);
        tick();
        clab_a = 1'b0;
        chk_a("m1_clr", 7'b1000010, 4'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_a($sformatf("m1_add%0d", i), {2'b00, 1'b1, (i == 7), 3'b010}, 4'(i));
            tick();
            chk_a($sformatf("m1_shift%0d", i), 7'b0000110, 4'(i));
        end
        tick();
        chk_a("m1_done", 7'b0000001, 4'd8);

        // Run held after DONE: no restart, no strobes
        tick();
        chk_a("done_hold1", 7'b0000001, 4'd8);
        tick();
        chk_a("done_hold2", 7'b0000001, 4'd8);
        run_a = 1'b0;
        #1;
        chk_a("done_run_low_same_cycle", 7'b0000001, 4'd8);
        tick();
        chk_a("back_to_idle", 7'b0000000, 4'd8);
        chk_state("idle_state_a", state_a, 3'd0);

        // new run with M=0: no AddEn, Sub_Add still on last ADD
        m_a = 1'b0; run_a = 1'b1;
        tick();
        chk_a("m0_clr", 7'b1000010, 4'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_a($sformatf("m0_add%0d", i), {2'b00, 1'b0, (i == 7), 3'b010}, 4'(i));
            tick();
            chk_a($sformatf("m0_shift%0d", i), 7'b0000110, 4'(i));
        end
        tick();
        chk_a("m0_done", 7'b0000001, 4'd8);
        run_a = 1'b0;
        tick();
        chk_a("m0_idle", 7'b0000000, 4'd8);

        // reset during ADD with Iter=4
        m_a = 1'b1; run_a = 1'b1;
        tick();
        chk_a("rst_run_clr", 7'b1000010, 4'd0);
        for (int k = 0; k < 9; k++) tick();
        chk_a("rst_run_add4", 7'b0010010, 4'd4);
        Reset = 1'b1; run_a = 1'b0;
        #1;
        chk_a("rst_mid_masked", 7'b0000000, 4'd0);
        tick();
        chk_a("rst_mid_held", 7'b0000000, 4'd0);
        chk_state("rst_mid_state", state_a, 3'd0);
        Reset = 1'b0;
        #1;
        chk_a("rst_release_idle", 7'b0000000, 4'd0);
        tick();
        chk_a("rst_release_stays", 7'b0000000, 4'd0);

        // CLEAR_ON_RUN=0: no CLR state, clab ignored mid-run, Busy 16 cycles
        run_b = 1'b1; clab_b = 1'b1;
        #1;
        chk_b("b_run_wins", 7'b0000000, 4'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            clab_b = (i == 2 || i == 5);
            m_b    = (i % 3 == 0);
            #1;
            chk_b($sformatf("b_add%0d", i), {2'b00, (i % 3 == 0), (i == 7), 3'b010}, 4'(i));
            tick();
            chk_b($sformatf("b_shift%0d", i), 7'b0000110, 4'(i));
        end
        clab_b = 1'b0;
        tick();
        chk_b("b_done", 7'b0000001, 4'd8);
        run_b = 1'b0;
        tick();
        chk_b("b_idle", 7'b0000000, 4'd8);
        chk_state("b_idle_state", state_b, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
